// File: rtl/mix_add_char.sv
// mix_add_char: MIX sign-magnitude add/subtract and binary-to-decimal CHAR conversion.
module mix_add_char (
    input  logic        clk,
    input  logic        reset,
    input  logic        add_start,
    input  logic        add_sub,
    input  logic [30:0] add_in1,
    input  logic [30:0] add_in2,
    output logic        add_stop,
    output logic [30:0] add_out,
    output logic        add_ovf,
    input  logic        char_start,
    input  logic [29:0] char_in,
    output logic        char_busy,
    output logic        char_stop,
    output logic [59:0] char_out
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    logic [29:0] m1, m2, mag;
    logic [30:0] sum;
    logic        s1, s2, same, ge, sgn, ovf;
    state_t      state, next;
    logic [4:0]  cnt;
    logic [29:0] bin;
    logic [39:0] bcd, adj, bcd_next;
    logic [59:0] codes;
    assign m1   = add_in1[29:0];
    assign m2   = add_in2[29:0];
    assign s1   = add_in1[30];
    assign s2   = add_in2[30] ^ add_sub;
    assign same = s1 == s2;
    assign ge   = m1 >= m2;
    assign sum  = {1'b0, m1} + {1'b0, m2};
    assign mag  = same ? sum[29:0] : ge ? m1 - m2 : m2 - m1;
    // a zero result keeps rA's sign so MIX -0 survives
    assign sgn  = (mag == 30'd0 || same || ge) ? s1 : s2;
    assign ovf  = same & sum[30];
    always_ff @(posedge clk) begin
        if (reset) begin
            add_stop <= 1'b0;
            add_out  <= 31'd0;
            add_ovf  <= 1'b0;
        end else begin
            add_stop <= add_start;
            if (add_start) begin
                add_out <= {sgn, mag};
                add_ovf <= ovf;
            end
        end
    end
    genvar d;
    generate
        for (d = 0; d < 10; d++) begin : g_dig
            assign adj[4*d+3:4*d]   = bcd[4*d+3:4*d] >= 4'd5 ? bcd[4*d+3:4*d] + 4'd3 : bcd[4*d+3:4*d];
            assign codes[6*d+5:6*d] = 6'd30 + {2'b00, bcd_next[4*d+3:4*d]};
        end
    endgenerate
    assign bcd_next  = {adj[38:0], bin[29]};
    assign char_busy = state != IDLE;
    assign char_stop = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    always_comb begin
        next = state;
        if (state == IDLE && char_start)       next = CONV;
        else if (state == CONV && cnt == 5'd29) next = DONE;
        else if (state == DONE)                next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 5'd0;
            bin      <= 30'd0;
            bcd      <= 40'd0;
            char_out <= 60'd0;
        end else if (state == IDLE && char_start) begin
            cnt <= 5'd0;
            bin <= char_in;
            bcd <= 40'd0;
        end else if (state == CONV) begin
            cnt <= cnt + 5'd1;
            bin <= bin << 1;
            bcd <= bcd_next;
            if (cnt == 5'd29) char_out <= codes;
        end
    end
endmodule

// File: tb/tb_mix_add_char.sv
// tb_mix_add_char: directed checks of the ADD/SUB and CHAR engines.
module tb_mix_add_char;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        add_start = 1'b0, add_sub = 1'b0;
    logic [30:0] add_in1 = 31'd0, add_in2 = 31'd0;
    logic        add_stop, add_ovf;
    logic [30:0] add_out;
    logic        char_start = 1'b0;
    logic [29:0] char_in = 30'd0;
    logic        char_busy, char_stop;
    logic [59:0] char_out;
    int tests = 0, errors = 0;

    mix_add_char dut (
        .clk(clk), .reset(reset),
        .add_start(add_start), .add_sub(add_sub), .add_in1(add_in1), .add_in2(add_in2),
        .add_stop(add_stop), .add_out(add_out), .add_ovf(add_ovf),
        .char_start(char_start), .char_in(char_in),
        .char_busy(char_busy), .char_stop(char_stop), .char_out(char_out)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (add_stop !== 1'b0 || add_out !== 31'd0 || add_ovf !== 1'b0 ||
            char_busy !== 1'b0 || char_stop !== 1'b0 || char_out !== 60'd0) begin
            errors++;
            $display("FAIL reset: stop=%b out=%h ovf=%b busy=%b cstop=%b cout=%h, expected all zero",
                     add_stop, add_out, add_ovf, char_busy, char_stop, char_out);
        end
    endtask

    task automatic test_add();
        logic [30:0] a1[9] = '{31'h00000005, 31'h3FFFFFFF, 31'h00000003, 31'h40000005, 31'h00000005,
                               31'h3FFFFFFF, 31'h40000000, 31'h7FFFFFFF, 31'h4000000A};
        logic [30:0] a2[9] = '{31'h00000007, 31'h00000001, 31'h4000000A, 31'h40000005, 31'h00000007,
                               31'h3FFFFFFF, 31'h00000000, 31'h40000001, 31'h00000003};
        logic        sb[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [30:0] ex[9] = '{31'h0000000C, 31'h00000000, 31'h40000007, 31'h40000000, 31'h40000002,
                               31'h3FFFFFFE, 31'h40000000, 31'h40000000, 31'h4000000D};
        logic        ov[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            add_in1 = a1[i]; add_in2 = a2[i]; add_sub = sb[i]; add_start = 1'b1;
            @(negedge clk);
            add_start = 1'b0;
            tests++;
            if (add_stop !== 1'b1 || add_out !== ex[i] || add_ovf !== ov[i]) begin
                errors++;
                $display("FAIL add[%0d]: stop=%b out=%h ovf=%b, expected stop=1 out=%h ovf=%b",
                         i, add_stop, add_out, add_ovf, ex[i], ov[i]);
            end
            add_in1 = 31'h12345; add_in2 = 31'h54321;
            @(negedge clk);
            tests++;
            if (add_stop !== 1'b0 || add_out !== ex[i] || add_ovf !== ov[i]) begin
                errors++;
                $display("FAIL add_hold[%0d]: stop=%b out=%h ovf=%b, expected stop=0 out=%h ovf=%b",
                         i, add_stop, add_out, add_ovf, ex[i], ov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        add_in1 = 31'd100; add_in2 = 31'd1; add_sub = 1'b0; add_start = 1'b1;
        @(negedge clk);
        tests++;
        if (add_stop !== 1'b1 || add_out !== 31'h00000065) begin
            errors++;
            $display("FAIL b2b_first: stop=%b out=%h, expected stop=1 out=00000065", add_stop, add_out);
        end
        add_in1 = 31'd1; add_in2 = 31'd100; add_sub = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        tests++;
        if (add_stop !== 1'b1 || add_out !== 31'h40000063 || add_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: stop=%b out=%h ovf=%b, expected stop=1 out=40000063 ovf=0",
                     add_stop, add_out, add_ovf);
        end
        @(negedge clk);
        tests++;
        if (add_stop !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop_low: stop=%b, expected 0", add_stop);
        end
    endtask

    task automatic test_char();
        int c1[10] = '{30, 30, 30, 30, 30, 31, 32, 39, 37, 37};
        int c2[10] = '{31, 30, 37, 33, 37, 34, 31, 38, 32, 33};
        logic [59:0] e1 = 60'd0, e2 = 60'd0;
        int n;
        for (int i = 0; i < 10; i++) begin
            e1 = {e1[53:0], 6'(c1[i])};
            e2 = {e2[53:0], 6'(c2[i])};
        end
        char_in = 30'd12977; char_start = 1'b1;
        @(negedge clk);
        char_start = 1'b0; n = 1;
        tests++;
        if (char_busy !== 1'b1) begin
            errors++;
            $display("FAIL char_busy_start: busy=%b, expected 1", char_busy);
        end
        while (char_stop !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 31 || char_out !== e1 || char_busy !== 1'b1) begin
            errors++;
            $display("FAIL char_12977: cycles=%0d out=%h busy=%b, expected cycles=31 out=%h busy=1",
                     n, char_out, char_busy, e1);
        end
        @(negedge clk);
        tests++;
        if (char_stop !== 1'b0 || char_busy !== 1'b0 || char_out !== e1) begin
            errors++;
            $display("FAIL char_after_done: stop=%b busy=%b out=%h, expected stop=0 busy=0 out=%h",
                     char_stop, char_busy, char_out, e1);
        end
        char_in = 30'd1073741823; char_start = 1'b1;
        @(negedge clk);
        char_start = 1'b0; n = 1;
        while (char_stop !== 1'b1 && n < 40) begin
            char_start = (n == 5);
            char_in = (n == 5) ? 30'd5 : 30'd1073741823;
            if (n == 20 && char_out !== e1) begin
                tests++; errors++;
                $display("FAIL char_hold_busy: out=%h, expected %h", char_out, e1);
            end
            @(negedge clk);
            n++;
        end
        char_start = 1'b0;
        tests++;
        if (n != 31 || char_out !== e2) begin
            errors++;
            $display("FAIL char_max: cycles=%0d out=%h, expected cycles=31 out=%h", n, char_out, e2);
        end
        @(negedge clk);
        tests++;
        if (char_busy !== 1'b0 || char_stop !== 1'b0) begin
            errors++;
            $display("FAIL char_restart_ignored: busy=%b stop=%b, expected busy=0 stop=0",
                     char_busy, char_stop);
        end
    endtask

    task automatic test_char_reset();
        int stops = 0;
        char_in = 30'd12345; char_start = 1'b1;
        @(negedge clk);
        char_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (char_stop === 1'b1) stops++;
            @(negedge clk);
        end
        tests++;
        if (stops != 0 || char_busy !== 1'b0 || char_out !== 60'd0) begin
            errors++;
            $display("FAIL char_reset_abort: stops=%0d busy=%b out=%h, expected stops=0 busy=0 out=0",
                     stops, char_busy, char_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [59:0] e0 = 60'd0;
        int n;
        for (int i = 0; i < 10; i++) e0 = {e0[53:0], 6'd30};
        add_in1 = 31'd1; add_in2 = 31'd2; add_sub = 1'b0; add_start = 1'b1;
        char_in = 30'd0; char_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0; char_start = 1'b0; n = 1;
        tests++;
        if (add_stop !== 1'b1 || add_out !== 31'd3 || char_busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_add: stop=%b out=%h busy=%b, expected stop=1 out=00000003 busy=1",
                     add_stop, add_out, char_busy);
        end
        while (char_stop !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 31 || char_out !== e0) begin
            errors++;
            $display("FAIL simul_char: cycles=%0d out=%h, expected cycles=31 out=%h", n, char_out, e0);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_char();
        test_char_reset();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
